id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the RV32I core: accepts one decoded instruction per handshake, holds it in a single-entry ID/EX register, and presents fully resolved operands and func code to the ALU. It contains the architectural register file, performs operand forwarding and load-use stalling, and computes branch/jump targets. Downstream is the ALU/EX stage; upstream is the instruction decoder.

---
 rtl/id_ex_stage_pkg.sv | 92 +++++++++
 rtl/id_ex_stage_if.sv | 54 +++++
 rtl/id_ex_stage_regfile.sv | 41 ++++
 rtl/id_ex_stage.sv | 182 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I definitions: func codes, operand selects, class decode.
// Used by id_ex_stage; optional forwarding is IDEX_FORWARD_EN.
package id_ex_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] F_ADD   = 6'd0;
    localparam logic [5:0] F_SUB   = 6'd1;
    localparam logic [5:0] F_SLL   = 6'd2;
    localparam logic [5:0] F_SLT   = 6'd3;
    localparam logic [5:0] F_SLTU  = 6'd4;
    localparam logic [5:0] F_XOR   = 6'd5;
    localparam logic [5:0] F_SRL   = 6'd6;
    localparam logic [5:0] F_SRA   = 6'd7;
    localparam logic [5:0] F_OR    = 6'd8;
    localparam logic [5:0] F_AND   = 6'd9;
    localparam logic [5:0] F_ADDI  = 6'd16;
    localparam logic [5:0] F_SLTI  = 6'd17;
    localparam logic [5:0] F_SLTIU = 6'd18;
    localparam logic [5:0] F_XORI  = 6'd19;
    localparam logic [5:0] F_ORI   = 6'd20;
    localparam logic [5:0] F_ANDI  = 6'd21;
    localparam logic [5:0] F_SLLI  = 6'd22;
    localparam logic [5:0] F_SRLI  = 6'd23;
    localparam logic [5:0] F_SRAI  = 6'd24;
    localparam logic [5:0] F_LB    = 6'd32;
    localparam logic [5:0] F_LH    = 6'd33;
    localparam logic [5:0] F_LW    = 6'd34;
    localparam logic [5:0] F_LBU   = 6'd35;
    localparam logic [5:0] F_LHU   = 6'd36;
    localparam logic [5:0] F_SB    = 6'd40;
    localparam logic [5:0] F_SH    = 6'd41;
    localparam logic [5:0] F_SW    = 6'd42;
    localparam logic [5:0] F_BEQ   = 6'd48;
    localparam logic [5:0] F_BNE   = 6'd49;
    localparam logic [5:0] F_BLT   = 6'd50;
    localparam logic [5:0] F_BGE   = 6'd51;
    localparam logic [5:0] F_BLTU  = 6'd52;
    localparam logic [5:0] F_BGEU  = 6'd53;
    localparam logic [5:0] F_LUI   = 6'd56;
    localparam logic [5:0] F_AUIPC = 6'd57;
    localparam logic [5:0] F_JAL   = 6'd58;
    localparam logic [5:0] F_JALR  = 6'd59;

    typedef enum logic [2:0] {
        SEL_RS1,
        SEL_RS2,
        SEL_PC,
        SEL_IMM,
        SEL_FOUR
    } sel_e;

    typedef enum logic [3:0] {
        CL_R,
        CL_I,
        CL_LD,
        CL_ST,
        CL_BR,
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_NONE
    } cls_e;

    function automatic cls_e func_class(input logic [5:0] f);
        cls_e c;
        unique case (1'b1)
            (f <= F_AND):                 c = CL_R;
            (f >= F_ADDI && f <= F_SRAI): c = CL_I;
            (f >= F_LB && f <= F_LHU):    c = CL_LD;
            (f >= F_SB && f <= F_SW):     c = CL_ST;
            (f >= F_BEQ && f <= F_BGEU):  c = CL_BR;
            (f == F_LUI):                 c = CL_LUI;
            (f == F_AUIPC):               c = CL_AUIPC;
            (f == F_JAL):                 c = CL_JAL;
            (f == F_JALR):                c = CL_JALR;
            default:                      c = CL_NONE;
        endcase
        return c;
    endfunction

    function automatic logic rd_hit(
        input logic       v,
        input logic [4:0] rd,
        input logic [4:0] a,
        input logic [4:0] b
    );
        return v && (rd != 5'd0) && (rd == a || rd == b);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decoder / EX / MEM / WB bundle seen by id_ex_stage.
// slave is the stage view, master the surrounding pipeline.
interface id_ex_stage_if #(parameter int XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [5:0]      in_func;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_imm;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      alu_func;
    logic [XLEN-1:0] alu_right;
    logic [XLEN-1:0] alu_left;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_store_data;
    logic [XLEN-1:0] out_target;
    logic            mem_valid;
    logic            mem_is_load;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  in_valid, in_func, in_pc,
        input  in_rs1, in_rs2, in_rd, in_imm,
        input  flush, out_ready,
        input  mem_valid, mem_is_load,
        input  mem_rd, mem_data,
        input  wb_valid, wb_rd, wb_data,
        output in_ready, out_valid,
        output alu_func, alu_right, alu_left,
        output out_rd, out_store_data, out_target
    );

    modport master (
        output in_valid, in_func, in_pc,
        output in_rs1, in_rs2, in_rd, in_imm,
        output flush, out_ready,
        output mem_valid, mem_is_load,
        output mem_rd, mem_data,
        output wb_valid, wb_rd, wb_data,
        input  in_ready, out_valid,
        input  alu_func, alu_right, alu_left,
        input  out_rd, out_store_data, out_target
    );

endinterface

// File: rtl/id_ex_stage_regfile.sv
// Architectural register file: 2 async reads, 1 sync write, x0 = 0.
// Reads bypass a same-cycle write so callers never see stale data.
module id_ex_stage_regfile #(
    parameter int XLEN     = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [RF_DEPTH];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 :
                      (wr_en && waddr_i == raddr1_i) ? wdata_i :
                      regs_q[raddr1_i];

    assign rdata2_o = (raddr2_i == 5'd0) ? '0 :
                      (wr_en && waddr_i == raddr2_i) ? wdata_i :
                      regs_q[raddr2_i];

endmodule

// File: rtl/id_ex_stage.sv
// RV32I ID/EX stage: single-entry hold register, operand resolve, hazards.
// IDEX_FORWARD_EN enables MEM/WB forwarding; otherwise any match stalls.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    id_ex_stage_if.slave io
);

    typedef struct packed {
        cls_e            cls;
        logic [5:0]      func;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
    } ent_t;

    ent_t            ent_q, ent_d, cap;
    logic            valid_q, valid_d;
    cls_e            cls_in;
    logic            use1, use2;
    logic            stall;
    logic            out_valid, in_ready;
    logic [XLEN-1:0] rf1, rf2;
    logic [XLEN-1:0] rs1_v, rs2_v;
    sel_e            sel_r, sel_l;
    logic [XLEN-1:0] tgt, sd;

    id_ex_stage_regfile #(
        .XLEN     (XLEN),
        .RF_DEPTH (RF_DEPTH)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (io.wb_valid),
        .waddr_i  (io.wb_rd),
        .wdata_i  (io.wb_data),
        .raddr1_i (ent_q.rs1),
        .raddr2_i (ent_q.rs2),
        .rdata1_o (rf1),
        .rdata2_o (rf2)
    );

    // Unused sources are zeroed at capture so hazard logic needs no use flags.
    always_comb begin
        cls_in = func_class(io.in_func);
        use1 = (cls_in != CL_LUI) && (cls_in != CL_AUIPC) &&
               (cls_in != CL_JAL) && (cls_in != CL_NONE);
        use2 = (cls_in == CL_R) || (cls_in == CL_ST) ||
               (cls_in == CL_BR);
        cap      = '0;
        cap.cls  = cls_in;
        cap.func = io.in_func;
        cap.pc   = io.in_pc;
        cap.rs1  = use1 ? io.in_rs1 : 5'd0;
        cap.rs2  = use2 ? io.in_rs2 : 5'd0;
        cap.rd   = io.in_rd;
        cap.imm  = io.in_imm;
        if (cls_in == CL_LUI) begin
            cap.cls  = CL_I;
            cap.func = F_ADDI;
        end
    end

    assign out_valid = valid_q && !stall;
    assign in_ready  = !valid_q || (out_valid && io.out_ready);

    always_comb begin
        ent_d   = ent_q;
        valid_d = valid_q;
        if (io.flush) begin
            valid_d = 1'b0;
        end else if (io.in_valid && in_ready) begin
            valid_d = 1'b1;
            ent_d   = cap;
        end else if (out_valid && io.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ent_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
        end
    end

`ifdef IDEX_FORWARD_EN
    // WB forwarding comes from the regfile bypass, below MEM in priority.
    always_comb begin
        rs1_v = rf1;
        rs2_v = rf2;
        if (ent_q.rs1 != 5'd0 && io.mem_valid && !io.mem_is_load &&
            io.mem_rd == ent_q.rs1) begin
            rs1_v = io.mem_data;
        end
        if (ent_q.rs2 != 5'd0 && io.mem_valid && !io.mem_is_load &&
            io.mem_rd == ent_q.rs2) begin
            rs2_v = io.mem_data;
        end
        stall = rd_hit(io.mem_valid && io.mem_is_load, io.mem_rd,
                       ent_q.rs1, ent_q.rs2);
    end
`else
    logic unused_mem;
    assign unused_mem = ^{io.mem_data, io.mem_is_load};

    always_comb begin
        rs1_v = rf1;
        rs2_v = rf2;
        stall = rd_hit(io.mem_valid, io.mem_rd, ent_q.rs1, ent_q.rs2) ||
                rd_hit(io.wb_valid, io.wb_rd, ent_q.rs1, ent_q.rs2);
    end
`endif

    function automatic logic [XLEN-1:0] pick(
        input sel_e            s,
        input logic [XLEN-1:0] r1,
        input logic [XLEN-1:0] r2,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] imm
    );
        logic [XLEN-1:0] v;
        case (s)
            SEL_RS1:  v = r1;
            SEL_RS2:  v = r2;
            SEL_PC:   v = pc;
            SEL_IMM:  v = imm;
            SEL_FOUR: v = XLEN'(32'd4);
            default:  v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        sel_r = SEL_RS1;
        sel_l = SEL_IMM;
        tgt   = '0;
        sd    = '0;
        case (ent_q.cls)
            CL_R: sel_l = SEL_RS2;
            CL_BR: begin
                sel_l = SEL_RS2;
                tgt   = ent_q.pc + ent_q.imm;
            end
            CL_ST: sd = rs2_v;
            CL_AUIPC: sel_r = SEL_PC;
            CL_JAL: begin
                sel_r = SEL_PC;
                sel_l = SEL_FOUR;
                tgt   = ent_q.pc + ent_q.imm;
            end
            CL_JALR: begin
                sel_r = SEL_PC;
                sel_l = SEL_FOUR;
                tgt   = (rs1_v + ent_q.imm) & ~XLEN'(32'd1);
            end
            default: ;
        endcase
    end

    assign io.in_ready       = in_ready;
    assign io.out_valid      = out_valid;
    assign io.alu_func       = ent_q.func;
    assign io.alu_right      = pick(sel_r, rs1_v, rs2_v,
                                    ent_q.pc, ent_q.imm);
    assign io.alu_left       = pick(sel_l, rs1_v, rs2_v,
                                    ent_q.pc, ent_q.imm);
    assign io.out_rd         = ent_q.rd;
    assign io.out_store_data = sd;
    assign io.out_target     = tgt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expectations,
// a negedge monitor pops and compares issued ops and cycle probes.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    typedef struct packed {
        logic [5:0]  f;
        logic [31:0] r;
        logic [31:0] l;
        logic [4:0]  rd;
        logic [31:0] sd;
        logic [31:0] tg;
    } tx_t;

    typedef enum {K_OV, K_IR, K_RT, K_LF, K_TG, K_DRAIN} kind_e;

    typedef struct {
        kind_e       k;
        logic [31:0] v;
    } probe_t;

    typedef struct packed {
        logic [5:0]  f;
        logic [31:0] pc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  ef;
        logic [31:0] er;
        logic [31:0] el;
        logic [31:0] esd;
        logic [31:0] etg;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32)) bus();

    id_ex_stage #(.XLEN(32), .RF_DEPTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    tx_t    txq[$];
    probe_t pq[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    row_t   rows[7];

    tx_t         m_got, m_exp;
    probe_t      m_p;
    logic [31:0] m_act;

    always @(negedge clk) begin
        while (pq.size() > 0) begin
            m_p = pq.pop_front();
            case (m_p.k)
                K_OV:    m_act = {31'd0, bus.out_valid};
                K_IR:    m_act = {31'd0, bus.in_ready};
                K_RT:    m_act = bus.alu_right;
                K_LF:    m_act = bus.alu_left;
                K_TG:    m_act = bus.out_target;
                default: m_act = txq.size();
            endcase
            n_cmp++;
            if (m_act !== m_p.v) begin
                n_bad++;
                $display("FAIL probe %s @%0t: got %h want %h",
                         m_p.k.name(), $time, m_act, m_p.v);
            end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            m_got = '{bus.alu_func, bus.alu_right, bus.alu_left,
                      bus.out_rd, bus.out_store_data, bus.out_target};
            n_cmp++;
            if (txq.size() == 0) begin
                n_bad++;
                $display("FAIL issue @%0t: unexpected %h", $time, m_got);
            end else begin
                m_exp = txq.pop_front();
                if (m_got !== m_exp) begin
                    n_bad++;
                    $display("FAIL issue @%0t: got %h want %h",
                             $time, m_got, m_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.in_valid    = 1'b0;
        bus.in_func     = '0;
        bus.in_pc       = '0;
        bus.in_rs1      = '0;
        bus.in_rs2      = '0;
        bus.in_rd       = '0;
        bus.in_imm      = '0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;
        bus.mem_valid   = 1'b0;
        bus.mem_is_load = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
    endtask

    task automatic put(input logic [5:0] f, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.in_func  = f;
        bus.in_pc    = pc;
        bus.in_rs1   = r1;
        bus.in_rs2   = r2;
        bus.in_rd    = rd;
        bus.in_imm   = imm;
    endtask

    task automatic expect_tx(input logic [5:0] f, input logic [31:0] r,
                             input logic [31:0] l, input logic [4:0] rd,
                             input logic [31:0] sd, input logic [31:0] tg);
        tx_t t;
        t = '{f, r, l, rd, sd, tg};
        txq.push_back(t);
    endtask

    task automatic prb(input kind_e k, input logic [31:0] v);
        probe_t p;
        p.k = k;
        p.v = v;
        pq.push_back(p);
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        bus.wb_data  = d;
        step();
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        rows[0] = '{F_JALR, 32'h100, 5'd9, 5'd0, 5'd1, 32'd4,
                    F_JALR, 32'h100, 32'd4, 32'd0, 32'h2004};
        rows[1] = '{F_BEQ, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd0, 32'd8,
                    F_BEQ, 32'd5, 32'd9, 32'd0, 32'h4};
        rows[2] = '{F_SW, 32'h40, 5'd1, 5'd2, 5'd0, 32'd12,
                    F_SW, 32'd5, 32'd12, 32'd9, 32'd0};
        rows[3] = '{F_AUIPC, 32'h1000, 5'd1, 5'd2, 5'd10, 32'h3000,
                    F_AUIPC, 32'h1000, 32'h3000, 32'd0, 32'd0};
        rows[4] = '{F_LUI, 32'h50, 5'd1, 5'd2, 5'd11, 32'hABCD_E000,
                    F_ADDI, 32'd0, 32'hABCD_E000, 32'd0, 32'd0};
        rows[5] = '{F_JAL, 32'h200, 5'd1, 5'd2, 5'd1, 32'hFFFF_FFF8,
                    F_JAL, 32'h200, 32'd4, 32'd0, 32'h1F8};
        rows[6] = '{F_SLTI, 32'h60, 5'd1, 5'd2, 5'd12, 32'hFFFF_FFFF,
                    F_SLTI, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0};

        quiet();
        rst_n = 1'b0;
        step();
        prb(K_OV, 0); prb(K_IR, 1); prb(K_RT, 0);
        prb(K_LF, 0); prb(K_TG, 0);
        step();
        rst_n = 1'b1;
        step();

        // ADDI x1,x0,5: one-cycle latency
        put(F_ADDI, 32'h0, 5'd0, 5'd0, 5'd1, 32'd5);
        expect_tx(F_ADDI, 32'd0, 32'd5, 5'd1, 32'd0, 32'd0);
        prb(K_OV, 0);
        step();
        bus.in_valid = 1'b0;
        prb(K_OV, 1);
        step();
        prb(K_OV, 0);

        wr(5'd1, 32'd5);
        wr(5'd2, 32'd9);
        wr(5'd9, 32'h2001);

        // ADD x3,x1,x2 with MEM/WB activity
        put(F_ADD, 32'h0, 5'd1, 5'd2, 5'd3, 32'd0);
        step();
        bus.in_valid  = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd1;
        bus.mem_data  = 32'd7;
        bus.wb_valid  = 1'b1;
        bus.wb_rd     = 5'd2;
        bus.wb_data   = 32'd9;
`ifdef IDEX_FORWARD_EN
        bus.out_ready = 1'b0;
        prb(K_OV, 1); prb(K_RT, 7); prb(K_LF, 9);
        step();
        bus.mem_rd   = 5'd2;
        bus.mem_data = 32'd11;
        bus.out_ready = 1'b1;
        prb(K_RT, 5); prb(K_LF, 11);
        expect_tx(F_ADD, 32'd5, 32'd11, 5'd3, 32'd0, 32'd0);
        step();
        quiet();
`else
        prb(K_OV, 0);
        step();
        bus.mem_rd   = 5'd2;
        bus.mem_data = 32'd11;
        prb(K_OV, 0);
        step();
        quiet();
        prb(K_OV, 1);
        expect_tx(F_ADD, 32'd5, 32'd9, 5'd3, 32'd0, 32'd0);
        step();
`endif

        // load-use on x4
        put(F_ADD, 32'h0, 5'd4, 5'd0, 5'd5, 32'd0);
        step();
        bus.in_valid    = 1'b0;
        bus.mem_valid   = 1'b1;
        bus.mem_is_load = 1'b1;
        bus.mem_rd      = 5'd4;
        bus.mem_data    = 32'hBAD;
        prb(K_OV, 0); prb(K_IR, 0);
        step();
        bus.mem_valid   = 1'b0;
        bus.mem_is_load = 1'b0;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = 5'd4;
        bus.wb_data     = 32'h55;
`ifdef IDEX_FORWARD_EN
        prb(K_OV, 1); prb(K_RT, 32'h55);
        expect_tx(F_ADD, 32'h55, 32'd0, 5'd5, 32'd0, 32'd0);
        step();
        quiet();
`else
        prb(K_OV, 0);
        step();
        quiet();
        prb(K_OV, 1); prb(K_RT, 32'h55);
        expect_tx(F_ADD, 32'h55, 32'd0, 5'd5, 32'd0, 32'd0);
        step();
`endif

        // backpressure, then issue+accept on one edge
        put(F_SUB, 32'h0, 5'd1, 5'd2, 5'd7, 32'd0);
        step();
        put(F_ORI, 32'h0, 5'd1, 5'd0, 5'd8, 32'hF0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            prb(K_IR, 0); prb(K_OV, 1); prb(K_RT, 5); prb(K_LF, 9);
            step();
        end
        bus.out_ready = 1'b1;
        prb(K_IR, 1);
        expect_tx(F_SUB, 32'd5, 32'd9, 5'd7, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        prb(K_OV, 1);
        expect_tx(F_ORI, 32'd5, 32'hF0, 5'd8, 32'd0, 32'd0);
        step();

        // operand mapping / targets, back-to-back
        for (int i = 0; i < 7; i++) begin
            put(rows[i].f, rows[i].pc, rows[i].r1, rows[i].r2,
                rows[i].rd, rows[i].imm);
            expect_tx(rows[i].ef, rows[i].er, rows[i].el,
                      rows[i].rd, rows[i].esd, rows[i].etg);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();

        // flush with an incoming op, then flush of a held op
        put(F_ADDI, 32'h0, 5'd0, 5'd0, 5'd11, 32'd1);
        bus.flush = 1'b1;
        prb(K_IR, 1);
        step();
        quiet();
        prb(K_OV, 0);
        step();
        put(F_ADDI, 32'h0, 5'd0, 5'd0, 5'd12, 32'd2);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        prb(K_OV, 1);
        step();
        quiet();
        prb(K_OV, 0);
        step();

        // x0 is never written
        wr(5'd0, 32'hDEAD);
        put(F_ADD, 32'h0, 5'd0, 5'd0, 5'd13, 32'd0);
        expect_tx(F_ADD, 32'd0, 32'd0, 5'd13, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        step();

        // reset in the middle of a load-use stall
        put(F_ADD, 32'h0, 5'd1, 5'd0, 5'd14, 32'd0);
        step();
        bus.in_valid    = 1'b0;
        bus.mem_valid   = 1'b1;
        bus.mem_is_load = 1'b1;
        bus.mem_rd      = 5'd1;
        prb(K_OV, 0); prb(K_RT, 5);
        step();
        rst_n = 1'b0;
        prb(K_OV, 0); prb(K_IR, 1); prb(K_RT, 0);
        step();
        quiet();
        rst_n = 1'b1;
        prb(K_OV, 0);
        step();
        put(F_ADD, 32'h0, 5'd1, 5'd2, 5'd15, 32'd0);
        expect_tx(F_ADD, 32'd0, 32'd0, 5'd15, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        step();

        prb(K_DRAIN, 0);
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
